// File: rtl/issueq_multi_free_select.sv
// rtl/issueq_multi_free_select.sv - issue-queue entry allocator with multi-lane alloc and release
//
// Tracks which issue-queue entries are free. Each cycle it offers the ALLOC_WIDTH
// lowest-index free entries to dispatch. The grant is all-or-nothing across the
// requested lanes. Up to FREE_WIDTH entries can be released per cycle, and a
// flush frees every entry.
//
// Ports
//   clk           clock, rising edge
//   reset_n       asynchronous active-low reset
//   flush_i       free every entry at the next edge (wins over alloc/release)
//   allocReq_i    per-lane allocation request
//   allocCand_o   per-lane candidate index, lane 0 in the LSBs
//   allocCandV_o  per-lane candidate exists
//   allocGrant_o  every requested lane has a candidate
//   freeValid_i   per-lane release strobe
//   freeIdx_i     per-lane release index, lane 0 in the LSBs
//   freeCnt_o     registered number of free entries
//   doubleFree_o  sticky: a release hit an already-free entry or was duplicated
module issueq_multi_free_select #(
  parameter int ENTRIES     = 32,
  parameter int ENTRY_LOG   = 5,
  parameter int ALLOC_WIDTH = 4,
  parameter int FREE_WIDTH  = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            flush_i,
  input  logic [ALLOC_WIDTH-1:0]          allocReq_i,
  output logic [ALLOC_WIDTH*ENTRY_LOG-1:0] allocCand_o,
  output logic [ALLOC_WIDTH-1:0]          allocCandV_o,
  output logic                            allocGrant_o,
  input  logic [FREE_WIDTH-1:0]           freeValid_i,
  input  logic [FREE_WIDTH*ENTRY_LOG-1:0] freeIdx_i,
  output logic [ENTRY_LOG:0]              freeCnt_o,
  output logic                            doubleFree_o
);

  localparam int CW = ENTRY_LOG + 1;

  logic [ENTRIES-1:0] freeVec;
  logic [ENTRIES-1:0] nextVec;
  logic [ENTRIES-1:0] allocMask;
  logic [ENTRIES-1:0] relMask;
  logic [CW-1:0]      freeCnt;
  logic [CW-1:0]      nextCnt;
  logic [CW-1:0]      allocCnt;
  logic [CW-1:0]      relCnt;
  logic [CW-1:0]      seen;
  logic               doubleFree;
  logic               badRel;

  // Candidate i is the i-th set bit scanning upward from entry 0. The selection uses
  // only the registered vector, so a release becomes visible one cycle later.
  always_comb begin
    allocCand_o  = '0;
    allocCandV_o = '0;
    seen         = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      if (freeVec[e]) begin
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
          if (seen == CW'(i)) begin
            allocCand_o[i*ENTRY_LOG +: ENTRY_LOG] = ENTRY_LOG'(e);
            allocCandV_o[i]                       = 1'b1;
          end
        end
        seen = seen + CW'(1);
      end
    end
  end

  assign allocGrant_o = &(allocCandV_o | ~allocReq_i);

  always_comb begin
    allocMask = '0;
    allocCnt  = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      if (allocGrant_o && allocReq_i[i]) begin
        allocMask[allocCand_o[i*ENTRY_LOG +: ENTRY_LOG]] = 1'b1;
        allocCnt = allocCnt + CW'(1);
      end
    end

    // relMask accumulates across lanes, so a second lane hitting the same index
    // is flagged and the entry is still set only once.
    relMask = '0;
    badRel  = 1'b0;
    for (int j = 0; j < FREE_WIDTH; j++) begin
      if (freeValid_i[j] && (int'(freeIdx_i[j*ENTRY_LOG +: ENTRY_LOG]) < ENTRIES)) begin
        if (freeVec[freeIdx_i[j*ENTRY_LOG +: ENTRY_LOG]] ||
            relMask[freeIdx_i[j*ENTRY_LOG +: ENTRY_LOG]]) begin
          badRel = 1'b1;
        end
        relMask[freeIdx_i[j*ENTRY_LOG +: ENTRY_LOG]] = 1'b1;
      end
    end

    // Count only releases that actually turn an allocated entry free.
    relCnt = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      if (relMask[e] && !freeVec[e]) begin
        relCnt = relCnt + CW'(1);
      end
    end

    nextVec = (freeVec & ~allocMask) | relMask;
    nextCnt = freeCnt - allocCnt + relCnt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      freeVec    <= '1;
      freeCnt    <= CW'(ENTRIES);
      doubleFree <= 1'b0;
    end else if (flush_i) begin
      freeVec <= '1;
      freeCnt <= CW'(ENTRIES);
    end else begin
      freeVec <= nextVec;
      freeCnt <= nextCnt;
      if (badRel) begin
        doubleFree <= 1'b1;
      end
    end
  end

  assign freeCnt_o    = freeCnt;
  assign doubleFree_o = doubleFree;

endmodule

// File: tb/tb_issueq_multi_free_select.sv
// tb/tb_issueq_multi_free_select.sv - directed self-checking bench for issueq_multi_free_select
module tb_issueq_multi_free_select;

  localparam int L = 5;

  logic          clk;
  logic          reset_n;
  logic          flush_i;
  logic [3:0]    allocReq_i;
  logic [4*L-1:0] allocCand_o;
  logic [3:0]    allocCandV_o;
  logic          allocGrant_o;
  logic [3:0]    freeValid_i;
  logic [4*L-1:0] freeIdx_i;
  logic [L:0]    freeCnt_o;
  logic          doubleFree_o;

  int checks;
  int errors;

  issueq_multi_free_select #(
    .ENTRIES(32), .ENTRY_LOG(5), .ALLOC_WIDTH(4), .FREE_WIDTH(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .flush_i(flush_i),
    .allocReq_i(allocReq_i),
    .allocCand_o(allocCand_o),
    .allocCandV_o(allocCandV_o),
    .allocGrant_o(allocGrant_o),
    .freeValid_i(freeValid_i),
    .freeIdx_i(freeIdx_i),
    .freeCnt_o(freeCnt_o),
    .doubleFree_o(doubleFree_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] packCands(input int c0, input int c1, input int c2, input int c3);
    return {5'(c3), 5'(c2), 5'(c1), 5'(c0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush_i     = 1'b0;
    allocReq_i  = 4'b0000;
    freeValid_i = 4'b0000;
    freeIdx_i   = '0;
  endtask

  task automatic doReset();
    idle();
    reset_n = 1'b0;
    #13;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    doReset();
    #1;
    checks++;
    if (freeCnt_o !== 6'd32) begin
      errors++; $display("FAIL reset_freeCnt got %0d want 32", freeCnt_o);
    end
    checks++;
    if (doubleFree_o !== 1'b0) begin
      errors++; $display("FAIL reset_doubleFree got %b want 0", doubleFree_o);
    end
    checks++;
    if (allocCandV_o !== 4'b1111 || allocCand_o !== packCands(0, 1, 2, 3)) begin
      errors++; $display("FAIL reset_cands got v=%b c=%h want v=1111 c=%h", allocCandV_o, allocCand_o, packCands(0, 1, 2, 3));
    end
    checks++;
    if (allocGrant_o !== 1'b1) begin
      errors++; $display("FAIL reset_grant_noreq got %b want 1", allocGrant_o);
    end
  endtask

  task automatic test_basic_alloc();
    allocReq_i = 4'b1111;
    #1;
    checks++;
    if (allocGrant_o !== 1'b1 || allocCand_o !== packCands(0, 1, 2, 3)) begin
      errors++; $display("FAIL basic_first got g=%b c=%h want g=1 c=%h", allocGrant_o, allocCand_o, packCands(0, 1, 2, 3));
    end
    tick();
    idle();
    #1;
    checks++;
    if (allocCand_o !== packCands(4, 5, 6, 7) || freeCnt_o !== 6'd28) begin
      errors++; $display("FAIL basic_second got c=%h cnt=%0d want c=%h cnt=28", allocCand_o, freeCnt_o, packCands(4, 5, 6, 7));
    end
  endtask

  task automatic test_exhaust();
    for (int k = 0; k < 7; k++) begin
      allocReq_i = 4'b1111;
      tick();
    end
    allocReq_i = 4'b0001;
    #1;
    checks++;
    if (allocCandV_o !== 4'b0000 || allocGrant_o !== 1'b0 || freeCnt_o !== 6'd0) begin
      errors++; $display("FAIL exhaust_empty got v=%b g=%b cnt=%0d want v=0000 g=0 cnt=0", allocCandV_o, allocGrant_o, freeCnt_o);
    end
    checks++;
    if (allocCand_o !== 20'h0) begin
      errors++; $display("FAIL exhaust_candzero got %h want 0", allocCand_o);
    end
  endtask

  task automatic test_release_no_grant();
    allocReq_i  = 4'b0011;
    freeValid_i = 4'b0011;
    freeIdx_i   = {5'd0, 5'd0, 5'd17, 5'd5};
    #1;
    checks++;
    if (allocGrant_o !== 1'b0) begin
      errors++; $display("FAIL release_samecycle_grant got %b want 0", allocGrant_o);
    end
    tick();
    idle();
    #1;
    checks++;
    if (allocCandV_o !== 4'b0011 || allocCand_o[9:0] !== {5'd17, 5'd5} || freeCnt_o !== 6'd2) begin
      errors++; $display("FAIL release_next got v=%b c=%h cnt=%0d want v=0011 c[9:0]=%h cnt=2", allocCandV_o, allocCand_o, freeCnt_o, {5'd17, 5'd5});
    end
  endtask

  task automatic test_all_or_nothing();
    allocReq_i = 4'b0111;
    #1;
    checks++;
    if (allocGrant_o !== 1'b0) begin
      errors++; $display("FAIL partial_grant got %b want 0", allocGrant_o);
    end
    tick();
    allocReq_i = 4'b0011;
    #1;
    checks++;
    if (freeCnt_o !== 6'd2 || allocCand_o[9:0] !== {5'd17, 5'd5} || allocGrant_o !== 1'b1) begin
      errors++; $display("FAIL partial_unchanged got cnt=%0d c=%h g=%b want cnt=2 c[9:0]=%h g=1", freeCnt_o, allocCand_o, allocGrant_o, {5'd17, 5'd5});
    end
    tick();
    idle();
    #1;
    checks++;
    if (freeCnt_o !== 6'd0 || allocCandV_o !== 4'b0000) begin
      errors++; $display("FAIL partial_consumed got cnt=%0d v=%b want cnt=0 v=0000", freeCnt_o, allocCandV_o);
    end
  endtask

  task automatic test_double_free();
    // Already-free target on a full queue.
    doReset();
    freeValid_i = 4'b0001;
    freeIdx_i   = {5'd0, 5'd0, 5'd0, 5'd9};
    tick();
    idle();
    #1;
    checks++;
    if (doubleFree_o !== 1'b1 || freeCnt_o !== 6'd32) begin
      errors++; $display("FAIL dbl_alreadyfree got d=%b cnt=%0d want d=1 cnt=32", doubleFree_o, freeCnt_o);
    end
    // Two lanes releasing the same allocated index.
    doReset();
    for (int k = 0; k < 8; k++) begin
      allocReq_i = 4'b1111;
      tick();
    end
    allocReq_i  = 4'b0000;
    freeValid_i = 4'b0011;
    freeIdx_i   = {5'd0, 5'd0, 5'd3, 5'd3};
    tick();
    idle();
    #1;
    checks++;
    if (doubleFree_o !== 1'b1 || freeCnt_o !== 6'd1 || allocCand_o[4:0] !== 5'd3) begin
      errors++; $display("FAIL dbl_duplane got d=%b cnt=%0d c0=%0d want d=1 cnt=1 c0=3", doubleFree_o, freeCnt_o, allocCand_o[4:0]);
    end
    freeValid_i = 4'b0001;
    freeIdx_i   = {5'd0, 5'd0, 5'd0, 5'd9};
    tick();
    idle();
    #1;
    checks++;
    if (doubleFree_o !== 1'b1 || freeCnt_o !== 6'd2 || allocCand_o[9:0] !== {5'd9, 5'd3}) begin
      errors++; $display("FAIL dbl_sticky got d=%b cnt=%0d c=%h want d=1 cnt=2 c[9:0]=%h", doubleFree_o, freeCnt_o, allocCand_o, {5'd9, 5'd3});
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    allocReq_i = 4'b1111;
    tick();
    allocReq_i  = 4'b1111;
    freeValid_i = 4'b0011;
    freeIdx_i   = {5'd0, 5'd0, 5'd2, 5'd1};
    #1;
    checks++;
    if (allocCand_o !== packCands(4, 5, 6, 7) || allocGrant_o !== 1'b1) begin
      errors++; $display("FAIL b2b_latency got c=%h g=%b want c=%h g=1", allocCand_o, allocGrant_o, packCands(4, 5, 6, 7));
    end
    tick();
    idle();
    #1;
    checks++;
    if (freeCnt_o !== 6'd26 || allocCand_o !== packCands(1, 2, 8, 9) || doubleFree_o !== 1'b0) begin
      errors++; $display("FAIL b2b_next got cnt=%0d c=%h d=%b want cnt=26 c=%h d=0", freeCnt_o, allocCand_o, doubleFree_o, packCands(1, 2, 8, 9));
    end
  endtask

  task automatic test_flush();
    doReset();
    allocReq_i = 4'b1111;
    tick();
    flush_i     = 1'b1;
    allocReq_i  = 4'b1111;
    freeValid_i = 4'b0001;
    freeIdx_i   = {5'd0, 5'd0, 5'd0, 5'd10};
    tick();
    idle();
    #1;
    checks++;
    if (freeCnt_o !== 6'd32 || allocCand_o !== packCands(0, 1, 2, 3)) begin
      errors++; $display("FAIL flush_state got cnt=%0d c=%h want cnt=32 c=%h", freeCnt_o, allocCand_o, packCands(0, 1, 2, 3));
    end
    checks++;
    if (doubleFree_o !== 1'b0) begin
      errors++; $display("FAIL flush_nodbl got %b want 0", doubleFree_o);
    end
  endtask

  task automatic test_mid_reset();
    allocReq_i  = 4'b1111;
    tick();
    freeValid_i = 4'b0011;
    freeIdx_i   = {5'd0, 5'd0, 5'd7, 5'd7};
    tick();
    idle();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (freeCnt_o !== 6'd32 || doubleFree_o !== 1'b0 || allocCand_o !== packCands(0, 1, 2, 3)) begin
      errors++; $display("FAIL midreset got cnt=%0d d=%b c=%h want cnt=32 d=0 c=%h", freeCnt_o, doubleFree_o, allocCand_o, packCands(0, 1, 2, 3));
    end
    #3;
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    idle();
    test_reset();
    test_basic_alloc();
    test_exhaust();
    test_release_no_grant();
    test_all_or_nothing();
    test_double_free();
    test_back_to_back();
    test_flush();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
